// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: padder state encoding, block layout constants,
// the last-beat byte-masking helper, and the IV/K tables used by the processor.
package sha256_pkg;

   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_PAD   = 2'd1,
      ST_EMIT  = 2'd2,
      ST_EXTRA = 2'd3
   } pad_state_t;

   localparam int          WORDS_PER_BLOCK = 16;
   localparam logic [31:0] PAD_MARKER      = 32'h8000_0000;
   localparam int          LEN_WORD_HI     = 14;
   localparam int          LEN_WORD_LO     = 15;

   localparam logic [31:0] SHA256_IV [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam logic [31:0] SHA256_K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   // Keep the first nbytes bytes, put the 0x80 marker right after them.
   function automatic logic [31:0] pad_last_word(input logic [31:0] data,
                                                 input logic [2:0]  nbytes);
      logic [31:0] w;
      case (nbytes)
         3'd0:    w = PAD_MARKER;
         3'd1:    w = {data[31:24], 24'h80_0000};
         3'd2:    w = {data[31:16], 16'h8000};
         3'd3:    w = {data[31:8],  8'h80};
         default: w = data;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs 32-bit beats into 512-bit blocks, appends the
// marker and bit length. Define SHA256_PADDER_STATS_EN to add blk_count.
//
// state    | meaning
// ST_FILL  | accepting message words into the block buffer
// ST_PAD   | one cycle: zero tail words, insert length or flag an extra block
// ST_EMIT  | block presented on out_*, waiting for out_ready
// ST_EXTRA | one cycle: build the trailing length-only block
module sha256_padder
   import sha256_pkg::*;
#(
   parameter int BYTE_CNT_W = 32
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [31:0]  in_data,
   input  logic         in_last,
   input  logic [2:0]   in_nbytes,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [511:0] out_block,
   output logic         out_first,
   output logic         out_last,
`ifdef SHA256_PADDER_STATS_EN
   output logic [15:0]  blk_count,
`endif
   output logic         busy
);

   pad_state_t             state, state_nxt;
   logic [4:0]             widx;
   logic [BYTE_CNT_W-1:0]  byte_cnt;
   logic [31:0]            blk [WORDS_PER_BLOCK];
   logic                   first_arm, final_blk, need_extra, marker_extra;
   logic                   in_msg, rdy_en;
   logic                   in_hs, out_hs;
   logic [63:0]            bitlen;

   assign bitlen    = 64'({byte_cnt, 3'b000});
   assign in_hs     = in_valid && in_ready;
   assign out_hs    = out_valid && out_ready;
   assign out_first = first_arm;
   assign out_last  = final_blk;
   assign busy      = in_msg || (state != ST_FILL);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= ST_FILL;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         ST_FILL: begin
            in_ready = rdy_en;
            if (in_valid && rdy_en) begin
               if (in_last)           state_nxt = ST_PAD;
               else if (widx == 5'd15) state_nxt = ST_EMIT;
            end
         end
         ST_PAD:   state_nxt = ST_EMIT;
         ST_EMIT: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = need_extra ? ST_EXTRA : ST_FILL;
         end
         ST_EXTRA: state_nxt = ST_EMIT;
         default:  state_nxt = ST_FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         widx         <= '0;
         byte_cnt     <= '0;
         first_arm    <= 1'b1;
         final_blk    <= 1'b0;
         need_extra   <= 1'b0;
         marker_extra <= 1'b0;
         in_msg       <= 1'b0;
         rdy_en       <= 1'b0;
         for (int i = 0; i < WORDS_PER_BLOCK; i++) blk[i] <= '0;
      end else begin
         rdy_en <= 1'b1;
         case (state)
            ST_FILL: if (in_hs) begin
               in_msg <= 1'b1;
               if (!in_last) begin
                  blk[widx[3:0]] <= in_data;
                  byte_cnt       <= byte_cnt + BYTE_CNT_W'(4);
                  final_blk      <= 1'b0;
                  need_extra     <= 1'b0;
                  marker_extra   <= 1'b0;
                  widx           <= widx + 5'd1;
               end else begin
                  blk[widx[3:0]] <= pad_last_word(in_data, in_nbytes);
                  byte_cnt       <= byte_cnt + BYTE_CNT_W'(in_nbytes);
                  if (in_nbytes >= 3'd4) begin
                     // Full last word: marker goes in the next word, or into
                     // word 0 of the extra block when this was word 15.
                     if (widx != 5'd15) blk[widx[3:0] + 4'd1] <= PAD_MARKER;
                     marker_extra <= (widx == 5'd15);
                     widx         <= widx + 5'd2;
                  end else begin
                     marker_extra <= 1'b0;
                     widx         <= widx + 5'd1;
                  end
               end
            end
            ST_PAD: begin
               for (int i = 0; i < WORDS_PER_BLOCK; i++)
                  if (5'(i) >= widx) blk[i] <= '0;
               if (widx <= 5'(LEN_WORD_HI)) begin
                  blk[LEN_WORD_HI] <= bitlen[63:32];
                  blk[LEN_WORD_LO] <= bitlen[31:0];
                  final_blk        <= 1'b1;
                  need_extra       <= 1'b0;
               end else begin
                  final_blk  <= 1'b0;
                  need_extra <= 1'b1;
               end
            end
            ST_EMIT: if (out_hs) begin
               first_arm <= final_blk;
               if (!need_extra) widx <= '0;
               if (final_blk) begin
                  final_blk <= 1'b0;
                  in_msg    <= 1'b0;
                  byte_cnt  <= '0;
               end
            end
            ST_EXTRA: begin
               for (int i = 0; i < WORDS_PER_BLOCK; i++) blk[i] <= '0;
               if (marker_extra) blk[0] <= PAD_MARKER;
               blk[LEN_WORD_HI] <= bitlen[63:32];
               blk[LEN_WORD_LO] <= bitlen[31:0];
               final_blk        <= 1'b1;
               need_extra       <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      out_block = '0;
      for (int i = 0; i < WORDS_PER_BLOCK; i++)
         out_block[511 - 32*i -: 32] = blk[i];
   end

`ifdef SHA256_PADDER_STATS_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)       blk_count <= '0;
      else if (out_hs) blk_count <= blk_count + 16'd1;
   end
`endif

endmodule
